// File: rtl/ram_reader_pkg.sv
// ram_reader_pkg: shared widths, buffer depth and FSM state type for the RAM read engine.
package ram_reader_pkg;
    localparam int RR_DATA_W    = 8;
    localparam int RR_ADDR_W    = 4;
    localparam int RR_BUF_DEPTH = 2;
    localparam int RR_OCC_W     = $clog2(RR_BUF_DEPTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} rr_state_t;
endpackage

// File: rtl/rr_skid_fifo.sv
// rr_skid_fifo: 2-entry synchronous FIFO buffering RAM read data for the output stream.
module rr_skid_fifo
    import ram_reader_pkg::*;
#(
    parameter int DATA_W = RR_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_push,
    input  logic [DATA_W-1:0]   i_data,
    input  logic                i_pop,
    output logic [DATA_W-1:0]   o_data,
    output logic [RR_OCC_W-1:0] o_occ,
    output logic                o_empty,
    output logic                o_full
);
    logic [DATA_W-1:0]   r_mem [RR_BUF_DEPTH];
    logic                r_wp;
    logic                r_rp;
    logic [RR_OCC_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wp     <= 1'b0;
            r_rp     <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wp] <= i_data;
                r_wp        <= ~r_wp;
            end
            if (i_pop) r_rp <= ~r_rp;
            r_cnt <= r_cnt + RR_OCC_W'(i_push) - RR_OCC_W'(i_pop);
        end
    end

    assign o_data  = r_mem[r_rp];
    assign o_occ   = r_cnt;
    assign o_empty = r_cnt == '0;
    assign o_full  = r_cnt == RR_OCC_W'(RR_BUF_DEPTH);
endmodule

// File: rtl/ram_reader.sv
// ram_reader: issues len wrapped reads from base_addr on the RAM read port and streams the
// returned words out on a valid/ready interface with credit-based back-pressure.
module ram_reader
    import ram_reader_pkg::*;
#(
    parameter int DATA_W = RR_DATA_W,
    parameter int ADDR_W = RR_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              re,
    output logic [ADDR_W-1:0] ra,
    input  logic [DATA_W-1:0] Dout,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready
);
    localparam int LW = ADDR_W + 1;
    localparam int CW = RR_OCC_W + 1;

    rr_state_t           r_state;
    rr_state_t           w_next;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W-1:0]   r_ra;
    logic [LW-1:0]       r_len;
    logic [LW-1:0]       r_issued;
    logic [LW-1:0]       r_accepted;
    logic                r_inflight;
    logic                r_done;
    logic                w_pop;
    logic                w_re;
    logic                w_accept;
    logic                w_last;
    logic                w_credit;
    logic                w_empty;
    logic                w_full;
    logic [ADDR_W-1:0]   w_addr;
    logic [RR_OCC_W-1:0] w_occ;

    assign w_pop    = m_valid && m_ready;
    // a read may issue only if its word is guaranteed a slot once it lands
    assign w_credit = CW'(w_occ) + CW'(r_inflight) < CW'(RR_BUF_DEPTH) + CW'(w_pop);
    assign w_addr   = r_base + r_issued[ADDR_W-1:0];

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_re     = 1'b0;
        w_last   = 1'b0;
        case (r_state)
            IDLE: begin
                w_accept = start && len != '0;
                if (w_accept) w_next = RUN;
            end
            RUN: begin
                w_re = r_issued < r_len && w_credit && (!w_full || w_pop);
                if (r_issued == r_len) w_next = DRAIN;
            end
            DRAIN: begin
                w_last = w_pop && r_accepted + LW'(1) == r_len;
                if (w_last) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_base     <= '0;
            r_len      <= '0;
            r_issued   <= '0;
            r_accepted <= '0;
            r_inflight <= 1'b0;
            r_ra       <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_inflight <= w_re;
            r_done     <= w_last;
            if (w_re) begin
                r_issued <= r_issued + LW'(1);
                r_ra     <= w_addr;
            end
            if (w_pop) r_accepted <= r_accepted + LW'(1);
            if (w_accept) begin
                r_base     <= base_addr;
                r_len      <= len;
                r_issued   <= '0;
                r_accepted <= '0;
            end
        end
    end

    assign busy    = r_state != IDLE;
    assign done    = r_done;
    assign re      = w_re;
    assign ra      = w_re ? w_addr : r_ra;
    assign m_valid = !w_empty;

    rr_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .i_push (r_inflight),
        .i_data (Dout),
        .i_pop  (w_pop),
        .o_data (m_data),
        .o_occ  (w_occ),
        .o_empty(w_empty),
        .o_full (w_full)
    );
endmodule

// File: tb/tb_ram_reader.sv
// tb_ram_reader: directed vector table plus hand sequences for the RAM read engine.
module tb_ram_reader;
    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          m_ready = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   len = '0;
    logic [DW-1:0] dout = '0;
    logic          busy, done, re, m_valid;
    logic [AW-1:0] ra;
    logic [DW-1:0] m_data;
    logic [DW-1:0] mem [16];

    int total = 0, bad = 0, cyc = 0, t0 = 0;
    int re_cnt = 0, done_cnt = 0, done_cyc = -1, valid_cnt = 0;
    int max_occ = 0, ovf = 0, stall_viol = 0;
    bit busy_seen = 1'b0;
    int beats[$];
    int beat_cyc[$];
    int ra_seen[$];

    typedef struct {
        int          base;
        int          len;
        logic [15:0] rdy;
        int          beats;
        int          first;
        int          last;
        int          res;
        int          dn;
        int          bsy;
    } vec_t;
    vec_t vt[7];

    ram_reader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base_addr(base_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .re       (re),
        .ra       (ra),
        .Dout     (dout),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (re) dout <= mem[ra];
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid && m_ready) begin
                beats.push_back(int'(m_data));
                beat_cyc.push_back(cyc);
            end
            if (re) begin
                re_cnt++;
                ra_seen.push_back(int'(ra));
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (m_valid) valid_cnt++;
            if (busy) busy_seen = 1'b1;
            if (int'(dut.u_fifo.o_occ) > max_occ) max_occ = int'(dut.u_fifo.o_occ);
            if (dut.u_fifo.i_push && dut.u_fifo.o_full && !(m_valid && m_ready)) ovf++;
            if (re && dut.u_fifo.o_full && !m_ready) stall_viol++;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic clear();
        re_cnt = 0;
        done_cnt = 0;
        done_cyc = -1;
        valid_cnt = 0;
        busy_seen = 1'b0;
        beats.delete();
        beat_cyc.delete();
        ra_seen.delete();
    endtask

    task automatic run_cmd(input int b, input int l, input logic [15:0] rdy, input int limit);
        clear();
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = AW'(b);
        len = (AW + 1)'(l);
        m_ready = rdy[0];
        t0 = cyc;
        for (int i = 1; i < limit; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            m_ready = rdy[i % 16];
            if (done_cnt != 0) break;
        end
        start = 1'b0;
        m_ready = 1'b1;
    endtask

    function automatic int beat_at(input int i);
        return i < beats.size() ? beats[i] : -1;
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int err, t1;
        for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
        vt[0] = '{0,  16, 16'hFFFF, 16, 'h10, 'h1F, 16, 1, 1};
        vt[1] = '{14, 4,  16'hFFFF, 4,  'h1E, 'h11, 4,  1, 1};
        vt[2] = '{3,  6,  16'hA9A9, 6,  'h13, 'h18, 6,  1, 1};
        vt[3] = '{0,  0,  16'hFFFF, 0,  0,    0,    0,  0, 0};
        vt[4] = '{5,  1,  16'hFFFF, 1,  'h15, 'h15, 1,  1, 1};
        vt[5] = '{15, 20, 16'hFFFF, 20, 'h1F, 'h12, 20, 1, 1};
        vt[6] = '{7,  5,  16'h0F0F, 5,  'h17, 'h1B, 5,  1, 1};

        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset re", int'(re), 0);
        chk("reset ra", int'(ra), 0);
        chk("reset m_valid", int'(m_valid), 0);
        chk("reset m_data", int'(m_data), 0);
        rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            run_cmd(vt[v].base, vt[v].len, vt[v].rdy, vt[v].dn != 0 ? 200 : 12);
            chk($sformatf("v%0d beats", v), beats.size(), vt[v].beats);
            chk($sformatf("v%0d re_count", v), re_cnt, vt[v].res);
            chk($sformatf("v%0d done_count", v), done_cnt, vt[v].dn);
            chk($sformatf("v%0d busy_seen", v), int'(busy_seen), vt[v].bsy);
            err = 0;
            for (int j = 0; j < beats.size(); j++)
                if (beats[j] != 'h10 + ((vt[v].base + j) % 16)) err++;
            chk($sformatf("v%0d data_order_errs", v), err, 0);
            err = 0;
            for (int j = 0; j < ra_seen.size(); j++)
                if (ra_seen[j] != (vt[v].base + j) % 16) err++;
            chk($sformatf("v%0d ra_order_errs", v), err, 0);
            if (beats.size() > 0) begin
                chk($sformatf("v%0d first", v), beats[0], vt[v].first);
                chk($sformatf("v%0d last", v), beats[beats.size() - 1], vt[v].last);
                chk($sformatf("v%0d latency", v), beat_cyc[0] - t0, 3);
                chk($sformatf("v%0d done_after_last", v), done_cyc - beat_cyc[beat_cyc.size() - 1], 1);
                if (vt[v].rdy == 16'hFFFF)
                    chk($sformatf("v%0d span", v), beat_cyc[beat_cyc.size() - 1] - beat_cyc[0], vt[v].beats - 1);
            end
        end

        // start during RUN must not disturb the running command
        clear();
        @(posedge clk); #1;
        start = 1'b1; base_addr = 4'd2; len = 5'd5; m_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 4'd9; len = 5'd3;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 100 && done_cnt == 0; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        chk("ignored_start beats", beats.size(), 5);
        chk("ignored_start first", beat_at(0), 'h12);
        chk("ignored_start last", beat_at(4), 'h16);
        chk("ignored_start re_count", re_cnt, 5);
        chk("ignored_start done_count", done_cnt, 1);

        // back-to-back: new start in the done cycle
        clear();
        @(posedge clk); #1;
        start = 1'b1; base_addr = 4'd6; len = 5'd2; m_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 50 && done !== 1'b1; i++) @(negedge clk);
        start = 1'b1; base_addr = 4'd4; len = 5'd2;
        @(posedge clk); #1;
        t1 = cyc;
        start = 1'b0;
        chk("b2b busy", int'(busy), 1);
        chk("b2b re", int'(re), 1);
        chk("b2b ra", int'(ra), 4);
        for (int i = 0; i < 50 && done_cnt < 2; i++) @(posedge clk);
        #1;
        chk("b2b beats", beats.size(), 4);
        chk("b2b beat0", beat_at(0), 'h16);
        chk("b2b beat2", beat_at(2), 'h14);
        chk("b2b beat3", beat_at(3), 'h15);
        chk("b2b latency", beat_cyc.size() > 2 ? beat_cyc[2] - t1 : -1, 2);

        // reset in the middle of a long read
        clear();
        @(posedge clk); #1;
        start = 1'b1; base_addr = 4'd0; len = 5'd16; m_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 100 && beats.size() < 5; i++) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst beats", beats.size(), 5);
        chk("midrst busy", int'(busy), 0);
        chk("midrst done", int'(done), 0);
        chk("midrst re", int'(re), 0);
        chk("midrst ra", int'(ra), 0);
        chk("midrst m_valid", int'(m_valid), 0);
        chk("midrst m_data", int'(m_data), 0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        clear();
        repeat (6) @(posedge clk);
        #1;
        chk("postrst stale_valid", valid_cnt, 0);
        chk("postrst re_count", re_cnt, 0);
        chk("postrst done_count", done_cnt, 0);
        run_cmd(0, 2, 16'hFFFF, 100);
        chk("postrst beats", beats.size(), 2);
        chk("postrst beat0", beat_at(0), 'h10);
        chk("postrst beat1", beat_at(1), 'h11);
        chk("postrst done_count", done_cnt, 1);

        chk("fifo overflow events", ovf, 0);
        chk("re while full and stalled", stall_viol, 0);
        chk("fifo peak occupancy", max_occ, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ram_reader.md
# ram_reader

Sequential read engine for the 16x8 dual-port RAM's read port. On a `start` command it issues `len` reads beginning at `base_addr`, wrapping modulo 16, and captures `Dout`. It delivers the words in order on a valid/ready output stream with full back-pressure support. It is the consumer-side counterpart to the write-port stimulus that fills the RAM.

## Interface
- `DATA_W`, default 8: RAM word width.
- `ADDR_W`, default 4: RAM address width; depth = 2^ADDR_W.
- `clk` — in, 1: sole clock; all state on rising edge.
- `rst` — in, 1: reset, asynchronous, active-high.
- `start` — in, 1: command strobe; sampled only in IDLE.
- `base_addr` — in, ADDR_W: first read address, sampled with `start`.
- `len` — in, ADDR_W+1: number of words to read (0..31), sampled with `start`.
- `busy` — out, 1: high from the cycle after an accepted start until `done`.
- `done` — out, 1: one-cycle pulse after the last word is accepted downstream.
- `re` — out, 1: RAM read enable.
- `ra` — out, ADDR_W: RAM read address.
- `Dout` — in, DATA_W: RAM read data, valid the cycle after `re` is sampled.
- `m_data` — out, DATA_W: output word.
- `m_valid` — out, 1: `m_data` valid.
- `m_ready` — in, 1: downstream accepts; a beat transfers when `m_valid && m_ready`.

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: on `start` with `len != 0`, latch `base_addr` and `len`, clear the issue and accept counters, go to RUN.
  - IDLE: `start` with `len == 0` is ignored; no `done` is produced.
  - RUN: issue reads under the credit rule. When issued == len, go to DRAIN.
  - DRAIN: wait until accepted == len, then pulse `done`, go to IDLE.
- `start` while not in IDLE is ignored. The latched command is not altered.
- Address: `ra = base + issued`, truncated to ADDR_W bits. Wrap 15→0 is required. `len` > 16 re-reads wrapped addresses.
- Output buffer: 2-entry FIFO.
  - An in-flight flag is set at each edge where `re` = 1.
  - On the following edge, `Dout` is pushed into the FIFO.
- Credit rule: `re` = RUN && issued < len && (occ + inflight − pop) < 2, where pop = `m_valid && m_ready`. The FIFO never overflows; the bench must assert this.
- `re` and `ra` are combinational from registered state. `ra` holds its last value when `re` = 0.
- Data order on `m_data` equals issue order. No word is dropped or duplicated under any `m_ready` pattern.
- Reset values: `busy`=0, `done`=0, `re`=0, `ra`=0, `m_valid`=0, `m_data`=0. State = IDLE, counters = 0, FIFO empty, in-flight cleared.
- Reset mid-operation aborts the command immediately. No `done` is produced, and stale `Dout` is not captured after release.

## Timing
- Edge E0 samples `start`.
- Cycle 1: `busy`=1, `re`=1, `ra`=base.
- Edge E1: the RAM samples the read.
- Edge E2: the FIFO captures the data.
- Cycle 3: `m_valid`=1. First-word latency is 3 cycles from E0.
- Throughput: 1 word/cycle with `m_ready` held high. Reads continue when occ=1 with a same-cycle pop.
- `m_ready` low: at most 2 words are buffered plus 0 in flight; `re` stalls until a pop frees credit.
- Last handshake at edge En: `done`=1 and `busy`=0 in cycle n+1. A new `start` is accepted at edge n+1.
- `len` = 1: `re` high for exactly one cycle; `done` follows the single handshake.

## Structure
- Package `ram_reader_pkg`:
  - state enum `rr_state_t` {IDLE, RUN, DRAIN};
  - default DATA_W/ADDR_W constants;
  - FIFO depth constant `RR_BUF_DEPTH` = 2.
- One sub-module, `rr_skid_fifo`: 2-entry synchronous FIFO.
  - Ports: push/pop, occupancy, empty/full.
  - Same `clk`/`rst`.
- The top level holds the FSM, counters, credit logic and address generation.

## Test plan
RAM model: 1-cycle read latency, preloaded `mem[i] = 8'h10 + i`.
- Straight read: base=0, len=16, `m_ready`=1 → `m_data` 8'h10..8'h1F on consecutive cycles 3..18, one `done` pulse, `re` count = 16.
- Wrap: base=14, len=4 → data 8'h1E, 8'h1F, 8'h10, 8'h11; `ra` sequence 14, 15, 0, 1.
- Back-pressure: base=3, len=6, `m_ready` toggled 1,0,0,1,0,1… → in-order 8'h13..8'h18, no loss or duplication, FIFO occupancy ≤ 2, `re` low while credit is exhausted.
- Edge commands:
  - len=0 → no `busy`, no `re`, no `done`;
  - `start` during RUN with base=9 → ignored, the original stream completes unchanged;
  - len=1 → single `re`, single beat, `done`.
- Reset mid-run: assert `rst` after 5 beats of a len=16 read → all outputs 0 asynchronously. After release, `m_valid` stays low. A fresh base=0, len=2 read returns 8'h10, 8'h11.
- Back-to-back: `start` in the cycle after `done` → accepted, first beat 3 cycles later.
